// File: rtl/ps2_frame_receiver_pkg.sv
// Shared constants, FSM encoding and a prefix-byte helper for the PS/2 receive path.
package ps2_pkg;
   localparam logic [7:0]  PS2_BREAK     = 8'hF0;
   localparam logic [7:0]  PS2_EXT       = 8'hE0;
   localparam int unsigned PS2_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_BREAK) || (b == PS2_EXT);
   endfunction
endpackage

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 pins plus decoded keycode outputs; master is the device/pin side, slave the receiver.
interface ps2_frame_receiver_if;
   logic        kclk;
   logic        kdata;
   logic [15:0] keycode;
   logic        oflag;
   logic        frame_err;

   modport master (output kclk, output kdata, input keycode, input oflag, input frame_err);
   modport slave  (input kclk, input kdata, output keycode, output oflag, output frame_err);
endinterface

// File: rtl/ps2_frame_receiver_line_filter.sv
// Two-flop synchronizer followed by a glitch filter; the output follows the line only
// after FILT_LEN consecutive equal samples. Idles high out of reset like a PS/2 line.
module ps2_line_filter #(
   parameter int unsigned FILT_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);
   localparam int unsigned CW = $clog2(FILT_LEN + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         cnt  <= '0;
         filt <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/ps2_frame_receiver.sv
// Decodes 11-bit PS/2 device-to-host frames into a rolling 16-bit keycode.
// Result appears the cycle after the stop-bit edge; stalled frames are dropped by a watchdog.
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILT_LEN       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ps2_frame_receiver_if.slave  ps2
);
   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_DATA   = DATA;
   localparam logic [1:0] S_PARITY = PARITY;
   localparam logic [1:0] S_STOP   = STOP;
   localparam int unsigned WW      = $clog2(TIMEOUT_CYCLES + 1);

   logic          kclk_f;
   logic          kdata_f;
   logic          kclk_q;
   logic          kclk_fall;
   logic [1:0]    state;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [WW-1:0] wdog;
   logic [15:0]   keycode_q;
   logic          oflag_q;
   logic          err_q;
   logic          frame_ok;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_kclk_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (ps2.kclk),
      .filt  (kclk_f)
   );

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_kdata_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (ps2.kdata),
      .filt  (kdata_f)
   );

   // Odd parity over data plus parity bit, and the stop bit must be high.
   assign frame_ok = (^{shreg, par_bit}) & kdata_f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_q    <= 1'b1;
         kclk_fall <= 1'b0;
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         wdog      <= '0;
         keycode_q <= '0;
         oflag_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         kclk_q    <= kclk_f;
         kclk_fall <= kclk_q & ~kclk_f;
         oflag_q   <= 1'b0;
         err_q     <= 1'b0;
         if (kclk_fall) begin
            wdog <= '0;
            case (state)
               S_IDLE: begin
                  if (!kdata_f) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shreg   <= {kdata_f, shreg[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(PS2_DATA_BITS - 1)) state <= S_PARITY;
               end
               S_PARITY: begin
                  par_bit <= kdata_f;
                  state   <= S_STOP;
               end
               default: begin
                  state   <= S_IDLE;
                  bit_cnt <= '0;
                  if (frame_ok) begin
                     keycode_q <= {keycode_q[7:0], shreg};
                     oflag_q   <= ~is_prefix(shreg);
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            endcase
         end else if (state != S_IDLE) begin
            if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
               state   <= S_IDLE;
               bit_cnt <= '0;
               wdog    <= '0;
               err_q   <= 1'b1;
            end else begin
               wdog <= wdog + WW'(1);
            end
         end else begin
            wdog <= '0;
         end
      end
   end

   assign ps2.keycode   = keycode_q;
   assign ps2.oflag     = oflag_q;
   assign ps2.frame_err = err_q;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench: table of known frame sequences, hand-built corner cases, then random frames.
module tb_ps2_frame_receiver;
   localparam int unsigned FILT_LEN = 8;
   localparam int unsigned TIMEOUT  = 1000;
   localparam int          HP       = 20;

   logic clk;
   logic rst_n;
   ps2_frame_receiver_if bus();

   ps2_frame_receiver #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ps2   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Pulse monitor: only this process writes these.
   int          n_of   = 0;
   int          n_er   = 0;
   int          n_both = 0;
   logic [15:0] last_kc = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.oflag) begin
            n_of    = n_of + 1;
            last_kc = bus.keycode;
         end
         if (bus.frame_err) n_er = n_er + 1;
         if (bus.oflag && bus.frame_err) n_both = n_both + 1;
      end
   end

   typedef struct {
      logic [7:0]  data;
      bit          bad_par;
      bit          bad_stop;
      logic [15:0] exp_kc;
      bit          exp_of;
      bit          exp_er;
   } vec_t;

   vec_t        tbl [11];
   logic [15:0] model_kc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      bus.kdata = b;
      if (glitch) begin
         cyc(6);
         bus.kclk = 1'b0;
         cyc(3);
         bus.kclk = 1'b1;
         cyc(HP - 9);
      end else begin
         cyc(HP);
      end
      bus.kclk = 1'b0;
      cyc(HP);
      bus.kclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit glitch);
      logic par;
      par = ~(^d) ^ bad_par;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
      send_bit(par, glitch);
      send_bit(~bad_stop, glitch);
      bus.kdata = 1'b1;
      cyc(HP);
   endtask

   // Reference: a frame is accepted iff parity is odd and stop is high; prefixes shift silently.
   task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              output bit of, output bit er);
      of = 1'b0;
      er = 1'b0;
      if (!bad_par && !bad_stop) begin
         model_kc = {model_kc[7:0], d};
         of = (d != 8'hF0) && (d != 8'hE0);
      end else begin
         er = 1'b1;
      end
   endtask

   task automatic frame_check(input string name, input int of0, input int er0,
                              input bit exp_of, input bit exp_er, input logic [15:0] exp_kc);
      @(negedge clk);
      check({name, " oflag pulses"}, 32'(n_of - of0), 32'(exp_of));
      check({name, " frame_err pulses"}, 32'(n_er - er0), 32'(exp_er));
      check({name, " keycode"}, {16'h0, bus.keycode}, {16'h0, exp_kc});
      if (exp_of) check({name, " keycode at oflag"}, {16'h0, last_kc}, {16'h0, exp_kc});
   endtask

   task automatic run_frame(input string name, input logic [7:0] d, input bit bp, input bit bs,
                            input bit glitch);
      int of0, er0;
      bit eo, ee;
      of0 = n_of;
      er0 = n_er;
      model_frame(d, bp, bs, eo, ee);
      send_frame(d, bp, bs, glitch);
      frame_check(name, of0, er0, eo, ee, model_kc);
   endtask

   initial begin
      int of0, er0;
      tbl[0]  = '{8'h1D, 0, 0, 16'h001D, 1, 0};
      tbl[1]  = '{8'hF0, 0, 0, 16'h1DF0, 0, 0};
      tbl[2]  = '{8'h1D, 0, 0, 16'hF01D, 1, 0};
      tbl[3]  = '{8'hE0, 0, 0, 16'h1DE0, 0, 0};
      tbl[4]  = '{8'hF0, 0, 0, 16'hE0F0, 0, 0};
      tbl[5]  = '{8'h75, 0, 0, 16'hF075, 1, 0};
      tbl[6]  = '{8'h1B, 1, 0, 16'hF075, 0, 1};
      tbl[7]  = '{8'h1B, 0, 0, 16'h751B, 1, 0};
      tbl[8]  = '{8'h55, 0, 1, 16'h751B, 0, 1};
      tbl[9]  = '{8'h1D, 0, 0, 16'h1B1D, 1, 0};
      tbl[10] = '{8'h1D, 0, 0, 16'h1D1D, 1, 0};

      bus.kclk  = 1'b1;
      bus.kdata = 1'b1;
      rst_n     = 1'b0;
      model_kc  = '0;
      cyc(5);
      @(negedge clk);
      check("reset keycode", {16'h0, bus.keycode}, 32'h0);
      check("reset oflag", {31'h0, bus.oflag}, 32'h0);
      check("reset frame_err", {31'h0, bus.frame_err}, 32'h0);
      rst_n = 1'b1;
      cyc(20);

      for (int i = 0; i < 11; i++) begin
         of0 = n_of;
         er0 = n_er;
         send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_stop, 1'b0);
         frame_check($sformatf("tbl[%0d]", i), of0, er0, tbl[i].exp_of, tbl[i].exp_er, tbl[i].exp_kc);
         model_kc = tbl[i].exp_kc;
      end

      // Stalled frame: start plus four data bits, then the clock stays high.
      of0 = n_of;
      er0 = n_er;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      bus.kdata = 1'b1;
      cyc(TIMEOUT + 200);
      frame_check("timeout", of0, er0, 1'b0, 1'b1, model_kc);
      run_frame("after timeout 72", 8'h72, 0, 0, 0);

      run_frame("glitched 29", 8'h29, 0, 0, 1);

      // Reset in the middle of a glitchy frame.
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
      rst_n = 1'b0;
      model_kc = '0;
      cyc(4);
      @(negedge clk);
      check("midreset keycode", {16'h0, bus.keycode}, 32'h0);
      check("midreset oflag", {31'h0, bus.oflag}, 32'h0);
      check("midreset frame_err", {31'h0, bus.frame_err}, 32'h0);
      bus.kdata = 1'b1;
      rst_n = 1'b1;
      cyc(30);
      run_frame("post reset 75", 8'h75, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         int r;
         bit bp, bs;
         r  = int'($urandom_range(99, 0));
         d  = 8'($urandom);
         if (r < 20) d = (r < 10) ? 8'hF0 : 8'hE0;
         bp = ($urandom_range(99, 0) < 15);
         bs = ($urandom_range(99, 0) < 10);
         run_frame($sformatf("rand[%0d] %02h", i, d), d, bp, bs, i[0]);
      end

      check("oflag and frame_err never together", n_both, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Front end of the keyboard path. Samples the raw PS/2 clock and data pins and decodes 11-bit device-to-host frames.
- Checks the start, odd-parity and stop bits, then assembles a 16-bit rolling keycode with a one-cycle valid flag.
- Output format is exactly what the downstream paddle-key decoder consumes: `keycode==16'hF0xx` on release, `keycode[7:0]==xx` on make.
- Sits between the board PS/2 pins and the key-state controller.

Parameters:
- FILT_LEN, 8, consecutive identical synchronized samples required before a filtered line changes; 160 ns at 50 MHz.
- TIMEOUT_CYCLES, 100000, clk cycles without a falling kclk edge mid-frame before the frame is aborted; 2 ms at 50 MHz.

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- kclk  in  1  raw PS/2 clock pin, asynchronous
- kdata  in  1  raw PS/2 data pin, asynchronous
- keycode  out  16  {previous valid byte, latest valid byte}
- oflag  out  1  one-cycle pulse: keycode holds a new non-prefix byte
- frame_err  out  1  one-cycle pulse: frame discarded (parity, stop or timeout)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: keycode=16'h0000, oflag=0, frame_err=0, FSM=IDLE, bit counter=0, watchdog=0, filtered kclk/kdata=1, sync flops=1.
- Input conditioning: 2-flop synchronizer per line. The filtered level takes the synchronized value only after FILT_LEN consecutive equal samples; shorter glitches are ignored.
- Edge detect: kclk_fall is a registered one-cycle pulse when filtered kclk goes 1->0. All bit sampling uses filtered kdata in the kclk_fall cycle.
- FSM states and transitions:
  - IDLE: on kclk_fall with kdata=0 (start bit) -> DATA, bit_cnt=0. On kclk_fall with kdata=1, stay in IDLE with no error.
  - DATA: on each kclk_fall, shift kdata in LSB-first and increment bit_cnt. After the 8th bit -> PARITY.
  - PARITY: on kclk_fall, capture the parity bit -> STOP.
  - STOP: on kclk_fall, the frame is valid iff XOR(data[7:0], parity)=1 AND kdata=1. Always -> IDLE.
- Valid frame (sampled in cycle N): in cycle N+1, keycode <= {keycode[7:0], byte}. oflag=1 in N+1 only if byte is not 8'hF0 and not 8'hE0.
- Prefix bytes: keycode still shifts, no oflag. Consequences:
  - sequence F0,1D -> single oflag with keycode=16'hF01D
  - sequence E0,F0,75 -> single oflag with keycode=16'hF075
  - make 1D after release -> keycode=16'h1D1D, oflag
- Invalid frame (parity or stop failure): keycode unchanged, oflag=0, frame_err=1 in cycle N+1.
- Watchdog: counts clk cycles while FSM≠IDLE and clears on every kclk_fall. On reaching TIMEOUT_CYCLES: FSM -> IDLE, bit_cnt=0, frame_err pulses one cycle, keycode unchanged.
- oflag and frame_err are never asserted in the same cycle. Each is at most one cycle per frame.
- Reset mid-frame: the partial frame is lost and all state returns to reset values immediately. The first frame after rst_n deasserts is decoded normally if its start edge arrives after the filter settles.
- Host-to-device transmission is not supported. The pins are inputs only.

Decomposition:
- Package ps2_pkg holds:
  - PS2_BREAK=8'hF0 and PS2_EXT=8'hE0
  - FSM state enum {IDLE, DATA, PARITY, STOP}
  - frame bit-count constant 8
- Sub-module ps2_line_filter (synchronizer + FILT_LEN glitch filter + reset-to-1), instantiated once for kclk and once for kdata.

Test Plan:
- Frame 0x1D (start 0, bits LSB-first, parity 1, stop 1) at 12.5 kHz from reset -> oflag pulse, keycode=16'h001D, frame_err never high.
- Frames F0 then 1D -> no oflag after F0 with keycode=16'h1DF0 held; oflag after 1D with keycode=16'hF01D.
- Frames E0, F0, 75 -> exactly one oflag, keycode=16'hF075.
- Frame 0x1B with parity bit 0 -> frame_err one-cycle pulse, no oflag, keycode unchanged; a following good 0x1B -> oflag, keycode[7:0]=8'h1B.
- Start bit plus 4 data bits, then kclk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM idle; next good 0x72 decodes correctly.
- 3-cycle low glitches on kclk between bits, plus rst_n pulsed low mid-frame -> glitches produce no extra bits; after reset all outputs=0 and the next good 0x75 gives keycode=16'h0075 with oflag.
